spfp_alu_seq: RTL and testbench
===============================

Name: spfp_alu_seq

Overview:
- Sequential front-end wrapped around the combinational SPFP ALU (add/sub/mul/div).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU from registered operands, holds them stable for a programmable settle time, then captures the result into an output register.
- Presents results in request order on a valid/ready handshake toward the downstream consumer.

Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of 2, at least 2.
- ALU_WAIT, 1: cycles operands are held on the ALU before the result is captured; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  32  operand 1, IEEE-754 single
- in_b  in  32  operand 2
- in_op  in  2  00 add, 01 sub, 10 mul, 11 div
- alu_n1  out  32  to ALU n1, registered
- alu_n2  out  32  to ALU n2, registered
- alu_s  out  2  to ALU s, registered
- alu_z  in  32  ALU result, combinational from alu_n1/alu_n2/alu_s
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_z  out  32  result
- out_op  out  2  op code of the result
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock edge with rst=1 clears all state.
  - FIFO becomes empty; count=0; in_ready=1 from the first cycle after reset.
  - FSM goes to IDLE.
  - alu_n1=0, alu_n2=0, alu_s=0.
  - out_valid=0, out_z=0, out_op=0; busy=0.
  - Reset mid-operation discards queued and in-flight requests; no result is emitted.
- FIFO:
  - in_ready = !full. No bypass: a push is refused when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- FSM states IDLE, EXEC, HOLD:
  - IDLE: if the FIFO is non-empty, pop the head into alu_n1/alu_n2/alu_s and the op latch, load wait counter = ALU_WAIT-1, then go to EXEC.
  - EXEC: operands are stable. Decrement the counter each cycle. When counter==0, capture alu_z into out_z and the op latch into out_op, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1. out_z and out_op are held stable while out_ready=0.
    - On out_valid && out_ready with the FIFO non-empty: pop the next request in the same edge, clear out_valid, go to EXEC (back-to-back).
    - On out_valid && out_ready with the FIFO empty: clear out_valid, go to IDLE.
- Timing:
  - Latency from an accepted request (cycle 0, empty FIFO, IDLE) to out_valid: cycle ALU_WAIT+2.
  - Sustained throughput with out_ready=1: one result per ALU_WAIT+1 cycles.
- alu_* outputs change only on a pop. Between pops they keep the last operands.
- No arithmetic is performed in this block; alu_z is passed through unmodified.

Optional Feature:
- Macro: SPFP_SEQ_FLAGS_EN.
- When defined: adds output port out_flags[3:0] = {nan, inf, zero, sign}, registered with out_z from alu_z.
  - nan: exp==FF and frac!=0
  - inf: exp==FF and frac==0
  - zero: exp==0 and frac==0
  - sign: bit 31
  - Reset value 0; held with out_z.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then add 0x3F800000 + 0x40000000 accepted at cycle 0 (ALU_WAIT=1) -> out_valid rises at cycle 3, out_z=0x40400000, out_op=00, busy drops after the handshake.
- Back-to-back with out_ready=1: mul 0x40000000*0x40400000, then div 0x40C00000/0x40000000 -> out_z=0x40C00000 then 0x40400000, exactly 2 cycles apart, in order.
- Backpressure: out_ready=0, push 6 requests -> in_ready=0 once count=4 (1 request in HOLD), rejected push not stored; release out_ready -> all 5 accepted results emerge in order, out_z stable while stalled.
- Wrap-around: 12 sequential subs with FIFO_DEPTH=4, random out_ready -> all 12 results correct and ordered; count never exceeds 4.
- Assert rst during EXEC with 3 entries queued -> next cycle count=0, out_valid=0, alu_n1=0, in_ready=1; no stale result appears afterwards.
- With SPFP_SEQ_FLAGS_EN, sub 0x3F800000 - 0x3F800000 -> out_z=0x00000000, out_flags=4'b0010.

Source files
------------

// File: rtl/spfp_alu_seq.sv
// Sequential front-end for the combinational SPFP ALU: request FIFO, operand
// registers with a programmable settle time, and a held result register.
// Optional macro SPFP_SEQ_FLAGS_EN adds out_flags_o = {nan, inf, zero, sign}.
module spfp_alu_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_WAIT   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [31:0]                   in_a_i,
  input  logic [31:0]                   in_b_i,
  input  logic [1:0]                    in_op_i,
  output logic [31:0]                   alu_n1_o,
  output logic [31:0]                   alu_n2_o,
  output logic [1:0]                    alu_s_o,
  input  logic [31:0]                   alu_z_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   out_z_o,
  output logic [1:0]                    out_op_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
`ifdef SPFP_SEQ_FLAGS_EN
  ,
  output logic [3:0]                    out_flags_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(ALU_WAIT - 1);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  req_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop, cap;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [31:0]   n1_q, n2_q, z_q;
  logic [1:0]    s_q, zop_q;
  logic          ov_q, ov_d;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // No bypass: a full FIFO refuses the push even if a pop happens this edge.
  assign push  = in_valid_i && !full;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= '{a: in_a_i, b: in_b_i, op: in_op_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ov_d    = ov_q;
    pop     = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        wcnt_d  = WAIT_LD;
        state_d = EXEC;
      end
      EXEC: if (wcnt_q == '0) begin
        cap     = 1'b1;
        ov_d    = 1'b1;
        state_d = HOLD;
      end else begin
        wcnt_d  = wcnt_q - 1'b1;
      end
      HOLD: if (out_ready_i) begin
        ov_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          wcnt_d  = WAIT_LD;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // alu_s doubles as the op latch: it only changes on a pop, like the operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ov_q    <= 1'b0;
      n1_q    <= '0;
      n2_q    <= '0;
      s_q     <= '0;
      z_q     <= '0;
      zop_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ov_q    <= ov_d;
      if (pop) begin
        n1_q <= mem_q[rptr_q].a;
        n2_q <= mem_q[rptr_q].b;
        s_q  <= mem_q[rptr_q].op;
      end
      if (cap) begin
        z_q   <= alu_z_i;
        zop_q <= s_q;
      end
    end
  end

`ifdef SPFP_SEQ_FLAGS_EN
  logic [3:0] flags_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) flags_q <= '0;
    else if (cap) flags_q <= {(alu_z_i[30:23] == 8'hFF) && (alu_z_i[22:0] != '0),
                              (alu_z_i[30:23] == 8'hFF) && (alu_z_i[22:0] == '0),
                              (alu_z_i[30:23] == 8'h00) && (alu_z_i[22:0] == '0),
                              alu_z_i[31]};
  end
  assign out_flags_o = flags_q;
`endif

  assign in_ready_o  = !full;
  assign alu_n1_o    = n1_q;
  assign alu_n2_o    = n2_q;
  assign alu_s_o     = s_q;
  assign out_valid_o = ov_q;
  assign out_z_o     = z_q;
  assign out_op_o    = zop_q;
  assign busy_o      = (state_q != IDLE) || !empty;
  assign count_o     = cnt_q;
endmodule

// File: tb/tb_spfp_alu_seq.sv
// Bench for spfp_alu_seq: behavioural SPFP ALU, driver pushing expected results
// to a scoreboard queue, and a negedge monitor comparing results as they leave.
module tb_spfp_alu_seq;
  localparam int D = 4;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [31:0] alu_n1, alu_n2, alu_z;
  logic [1:0]  alu_s;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic [1:0]  out_op;
  logic        busy;
  logic [2:0]  count;
`ifdef SPFP_SEQ_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  spfp_alu_seq #(.FIFO_DEPTH(D), .ALU_WAIT(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_op_i(in_op),
    .alu_n1_o(alu_n1), .alu_n2_o(alu_n2), .alu_s_o(alu_s), .alu_z_i(alu_z),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_z_o(out_z), .out_op_o(out_op),
    .busy_o(busy), .count_o(count)
`ifdef SPFP_SEQ_FLAGS_EN
    , .out_flags_o(out_flags)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-precision model (normals and zero; exact for the vectors used).
  function automatic real sp2real(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 8'h00) return 0.0;
    r = real'({1'b1, x[22:0]});
    e = int'(x[30:23]) - 150;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int          ex;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(ex), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    real x, y;
    x = sp2real(a);
    y = sp2real(b);
    case (op)
      2'd0: return real2sp(x + y);
      2'd1: return real2sp(x - y);
      2'd2: return real2sp(x * y);
      default: return (y == 0.0) ? 32'h0 : real2sp(x / y);
    endcase
  endfunction

  always_comb alu_z = fp_ref(alu_n1, alu_n2, alu_s);

  typedef struct {
    logic [31:0] z;
    logic [1:0]  op;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] z;
  } vec_t;

  exp_t        sb[$];
  int          pop_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        rnd_en = 1'b0, rnd_bit = 1'b0, ordy_man = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_z = '0;
  vec_t        vecs[8];

  assign out_ready = rnd_en ? rnd_bit : ordy_man;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [31:0] z);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck low, request %h op %0d", a, op);
    end else begin
      sb.push_back('{z: z, op: op});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    bit ok = 0;
    for (int n = 0; n < max; n++) begin
      if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  task automatic wait_ov(input int max);
    bit ok = 0;
    for (int n = 0; n < max; n++) begin
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("wait_out_valid", 32'(ok), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, 2'd0, 32'h40400000};
    vecs[1] = '{32'h40000000, 32'h40400000, 2'd2, 32'h40C00000};
    vecs[2] = '{32'h40C00000, 32'h40000000, 2'd3, 32'h40400000};
    vecs[3] = '{32'h3F800000, 32'h3F800000, 2'd1, 32'h00000000};
    vecs[4] = '{32'h40000000, 32'h40400000, 2'd1, 32'hBF800000};
    vecs[5] = '{32'h41200000, 32'h3F000000, 2'd0, 32'h41280000};
    vecs[6] = '{32'hC0000000, 32'h3F000000, 2'd2, 32'hBF800000};
    vecs[7] = '{32'h3F800000, 32'h40800000, 2'd3, 32'h3E800000};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;

    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(posedge clk); #1; rnd_bit = 1'($urandom_range(0, 1)); end
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin prev_stall = 1'b0; continue; end
        if (count > 3'(D)) chk("count_le_depth", 32'(count), 32'(D));
        if (prev_stall && out_valid) chk("out_z_stable", out_z, prev_z);
        prev_stall = out_valid && !out_ready;
        prev_z     = out_z;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %h with no request pending", out_z);
          end else begin
            e = sb.pop_front();
            chk("out_z", out_z, e.z);
            chk("out_op", 32'(out_op), 32'(e.op));
            pop_cyc.push_back(cyc);
          end
        end
      end
    join_none

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_outs", {out_z[29:0], out_op}, 32'd0);
    chk("rst_flags", {out_valid, busy}, 32'd0);
    chk("rst_alu", alu_n1 | alu_n2 | 32'(alu_s), 32'd0);

    // Latency: accepted at cycle 0, out_valid at cycle 3, busy low after handshake.
    send(32'h3F800000, 32'h40000000, 2'd0, 32'h40400000);
    @(negedge clk); chk("lat_c1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_c2_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_c3_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Back-to-back results exactly ALU_WAIT+1 cycles apart.
    pop_cyc.delete();
    send(32'h40000000, 32'h40400000, 2'd2, 32'h40C00000);
    send(32'h40C00000, 32'h40000000, 2'd3, 32'h40400000);
    wait_drain(50);
    chk("b2b_results", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) chk("b2b_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'(W + 1));

    // Table of vectors streamed through.
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].z);
    wait_drain(100);

    // Backpressure: fill FIFO behind a held result; sixth push must be refused.
    ordy_man = 1'b0;
    for (int i = 0; i < 5; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].z);
    in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h3F800000; in_op = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(count), 32'd4);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ordy_man = 1'b1;
    wait_drain(100);
    chk("bp_count_empty", 32'(count), 32'd0);

    // Wrap-around with random consumer stalls.
    rnd_en = 1'b1;
    for (int i = 0; i < 12; i++)
      send(real2sp(real'(3 * i + 20)), real2sp(real'(i)), 2'd1, real2sp(real'(2 * i + 20)));
    wait_drain(500);
    rnd_en = 1'b0;

    // Reset during EXEC with three requests queued.
    ordy_man = 1'b0;
    send(vecs[5].a, vecs[5].b, vecs[5].op, vecs[5].z);
    wait_ov(20);
    for (int i = 0; i < 4; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].z);
    ordy_man = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; ordy_man = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_alu_n1", alu_n1, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    ordy_man = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef SPFP_SEQ_FLAGS_EN
    ordy_man = 1'b0;
    send(32'h3F800000, 32'h3F800000, 2'd1, 32'h00000000);
    wait_ov(20);
    chk("flags_zero", 32'(out_flags), 32'b0010);
    ordy_man = 1'b1;
    wait_drain(50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
